// File: rtl/bus_port_ctl.sv
// bus_port_ctl: registered bidirectional bus port with request/grant/drive/turnaround sequencing
module bus_port_ctl #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_d,
  input  logic             a_ld,
  output logic             a_full,
  output logic [WIDTH-1:0] b_q,
  output logic             b_oe_,
  output logic             b_req,
  input  logic             b_gnt,
  input  logic [WIDTH-1:0] b_d,
  input  logic             b_ld,
  output logic [WIDTH-1:0] s_q,
  output logic             s_full,
  input  logic             a_rd,
  input  logic             s_ack,
  output logic             a_oe_,
  output logic             ovr,
  input  logic             ovr_clr
);
  typedef enum logic [1:0] {IDLE, FULL, DRIVE, TURN} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic r_load, s_load, set_ovr;
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    case (state)
      IDLE: state_nxt = a_ld ? FULL : IDLE;
      FULL: begin
        state_nxt = b_gnt ? DRIVE : FULL;
        cnt_nxt = b_gnt ? 4'(HOLD - 1) : cnt;
      end
      DRIVE: begin
        state_nxt = (cnt == 4'd0) ? TURN : DRIVE;
        cnt_nxt = (cnt == 4'd0) ? cnt : cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end
  assign r_load = (state == IDLE) && a_ld;
  assign s_load = b_ld && (!s_full || s_ack);
  assign set_ovr = (a_ld && state != IDLE) || (b_ld && s_full && !s_ack);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      b_q <= '0;
      s_q <= '0;
      s_full <= 1'b0;
      ovr <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      b_q <= r_load ? a_d : b_q;
      s_q <= s_load ? b_d : s_q;
      s_full <= s_load ? 1'b1 : (s_ack ? 1'b0 : s_full);
      ovr <= set_ovr ? 1'b1 : (ovr_clr ? 1'b0 : ovr);
    end
  end
  assign a_full = state != IDLE;
  assign b_req = state == FULL;
  assign b_oe_ = state != DRIVE;
  assign a_oe_ = ~(a_rd & s_full);
endmodule

// File: tb/tb_bus_port_ctl.sv
// tb_bus_port_ctl: three HOLD builds driven in parallel against a transaction-level model
module tb_bus_port_ctl;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, a_ld, b_gnt, b_ld, a_rd, s_ack, ovr_clr;
  logic [7:0] a_d, b_d;
  logic a_full [3], b_oe_ [3], b_req [3], s_full [3], a_oe_ [3], ovr [3];
  logic [7:0] b_q [3], s_q [3];
  int hv [3] = '{2, 1, 15};
  for (genvar g = 0; g < 3; g++) begin : u
    bus_port_ctl #(.WIDTH(8), .HOLD(g == 0 ? 2 : (g == 1 ? 1 : 15))) dut (
      .clk(clk), .rst(rst), .a_d(a_d), .a_ld(a_ld), .a_full(a_full[g]), .b_q(b_q[g]),
      .b_oe_(b_oe_[g]), .b_req(b_req[g]), .b_gnt(b_gnt), .b_d(b_d), .b_ld(b_ld),
      .s_q(s_q[g]), .s_full(s_full[g]), .a_rd(a_rd), .s_ack(s_ack), .a_oe_(a_oe_[g]),
      .ovr(ovr[g]), .ovr_clr(ovr_clr)
    );
  end
  bit m_full [3];
  int m_t [3];
  logic [7:0] m_r [3];
  bit m_ovr [3];
  bit m_sf;
  logic [7:0] m_s;
  int total = 0, npass = 0;
  int lowcnt [3];
  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) npass++;
    else $error("FAIL %s[HOLD=%0d] observed=%0h expected=%0h", tag, hv[i], obs, exp);
  endtask
  task automatic model;
    bit set_i;
    set_i = b_ld && m_sf && !s_ack;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_full[i] = 0; m_t[i] = -1; m_r[i] = 0; m_ovr[i] = 0;
      end else begin
        bit set_o;
        set_o = a_ld && m_full[i];
        if (!m_full[i] && a_ld) begin
          m_full[i] = 1; m_r[i] = a_d; m_t[i] = -1;
        end else if (m_full[i]) begin
          if (m_t[i] < 0) m_t[i] = b_gnt ? 0 : -1;
          else if (m_t[i] == hv[i]) m_full[i] = 0;
          else m_t[i]++;
        end
        m_ovr[i] = (set_o || set_i) ? 1 : (ovr_clr ? 0 : m_ovr[i]);
      end
    end
    if (rst) begin
      m_sf = 0; m_s = 0;
    end else if (b_ld && (!m_sf || s_ack)) begin
      m_sf = 1; m_s = b_d;
    end else if (s_ack) m_sf = 0;
  endtask
  task automatic step;
    @(posedge clk);
    model();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("a_full", i, 32'(a_full[i]), 32'(m_full[i]));
      chk("b_req", i, 32'(b_req[i]), 32'(m_full[i] && m_t[i] < 0));
      chk("b_oe_", i, 32'(b_oe_[i]), 32'(!(m_full[i] && m_t[i] >= 0 && m_t[i] < hv[i])));
      chk("b_q", i, 32'(b_q[i]), 32'(m_r[i]));
      chk("s_q", i, 32'(s_q[i]), 32'(m_s));
      chk("s_full", i, 32'(s_full[i]), 32'(m_sf));
      chk("a_oe_", i, 32'(a_oe_[i]), 32'(!(a_rd && m_sf)));
      chk("ovr", i, 32'(ovr[i]), 32'(m_ovr[i]));
      if (!b_oe_[i]) lowcnt[i]++;
    end
  endtask
  task automatic quiet(input int n);
    {rst, a_ld, b_gnt, b_ld, a_rd, s_ack, ovr_clr} = '0;
    repeat (n) step();
  endtask
  initial begin
    {a_ld, b_gnt, b_ld, a_rd, s_ack, ovr_clr} = '0;
    a_d = 0; b_d = 0; rst = 1;
    step();
    rst = 0;
    repeat (10) begin
      b_gnt = 1'($urandom); a_rd = 1'($urandom);
      step();
    end
    quiet(2);
    a_ld = 1; a_d = 8'hA5; step();
    a_ld = 0; step();
    b_gnt = 1; step();
    b_gnt = 0; repeat (20) step();
    a_ld = 1; a_d = 8'h11; step();
    a_d = 8'h22; step();
    chk("b_q_keeps_first", 0, 32'(b_q[0]), 32'h11);
    a_ld = 0; ovr_clr = 1; step();
    ovr_clr = 0; a_ld = 1; a_d = 8'h33; step();
    ovr_clr = 1; step();
    chk("ovr_set_wins", 0, 32'(ovr[0]), 32'd1);
    quiet(1);
    b_gnt = 1; step();
    quiet(18);
    ovr_clr = 1; step();
    ovr_clr = 0; b_ld = 1; b_d = 8'h3C; step();
    b_d = 8'h4D; s_ack = 1; step();
    b_ld = 0; s_ack = 0; a_rd = 1; step();
    chk("a_oe_low", 0, 32'(a_oe_[0]), 32'd0);
    s_ack = 1; step();
    chk("s_full_cleared", 0, 32'(s_full[0]), 32'd0);
    quiet(1);
    a_ld = 1; a_d = 8'h5A; step();
    a_ld = 0; b_gnt = 1; step();
    b_gnt = 0; step();
    rst = 1; step();
    rst = 0;
    chk("rst_drive_b_oe_", 0, 32'(b_oe_[0]), 32'd1);
    chk("rst_drive_b_q", 0, 32'(b_q[0]), 32'd0);
    a_ld = 1; a_d = 8'h77; step();
    a_ld = 0; step();
    chk("fresh_load", 0, 32'(b_q[0]), 32'h77);
    quiet(20);
    for (int i = 0; i < 3; i++) lowcnt[i] = 0;
    a_ld = 1; a_d = 8'hC3; step();
    a_ld = 0; b_gnt = 1; step();
    step();
    b_gnt = 0; repeat (20) step();
    for (int i = 0; i < 3; i++) chk("drive_len", i, 32'(lowcnt[i]), 32'(hv[i]));
    repeat (300) begin
      rst = ($urandom_range(0, 59) == 0);
      a_ld = ($urandom_range(0, 2) == 0); a_d = 8'($urandom);
      b_gnt = 1'($urandom); b_ld = ($urandom_range(0, 2) == 0); b_d = 8'($urandom);
      s_ack = ($urandom_range(0, 2) == 0); a_rd = 1'($urandom);
      ovr_clr = ($urandom_range(0, 7) == 0);
      step();
    end
    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end
endmodule
